// File: rtl/interface_de_entrada_autorep.sv
// Two-button input front end: synchronizes and debounces raw buttons, then
// turns held presses into count-enable steps with delayed auto-repeat.
module interface_de_entrada_autorep #(
  parameter int DEB_CICLOS  = 4,
  parameter int ATRASO_REP  = 16,
  parameter int PERIODO_REP = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_mais,
  input  logic btn_menos,
  output logic habilitar_contagem,
  output logic modo_contagem,
  output logic em_repeticao
);

  localparam int DW   = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam int TMAX = (ATRASO_REP > PERIODO_REP) ? ATRASO_REP : PERIODO_REP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DEB_MAX     = DW'(DEB_CICLOS - 1);
  localparam logic [TW-1:0] CARGA_ATRASO = TW'(ATRASO_REP - 1);
  localparam logic [TW-1:0] CARGA_PER    = TW'(PERIODO_REP - 1);

  typedef enum logic [1:0] {
    ESPERANDO,
    INCREMENTANDO,
    DECREMENTANDO,
    BLOQUEADO
  } estado_t;

  // Bit 0 carries the increment button, bit 1 the decrement button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [DW-1:0] deb_cnt [2];

  estado_t       state;
  estado_t       state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          pulso_next;
  logic          rep_next;
  logic          ativo_next;
  logic          fm;
  logic          fn;

  assign fm = filt[0];
  assign fn = filt[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_menos, btn_mais};
      sync2 <= sync1;
    end
  end

  // The filtered level only follows after DEB_CICLOS consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ESPERANDO: begin
        if (fm && fn)  state_next = BLOQUEADO;
        else if (fm)   state_next = INCREMENTANDO;
        else if (fn)   state_next = DECREMENTANDO;
      end
      INCREMENTANDO: begin
        if (fn)        state_next = BLOQUEADO;
        else if (!fm)  state_next = ESPERANDO;
      end
      DECREMENTANDO: begin
        if (fm)        state_next = BLOQUEADO;
        else if (!fn)  state_next = ESPERANDO;
      end
      BLOQUEADO: begin
        if (!fm && !fn) state_next = ESPERANDO;
      end
      default:         state_next = ESPERANDO;
    endcase

    // Entry gives the first step; the timer then paces the repeats.
    ativo_next = (state_next == INCREMENTANDO) || (state_next == DECREMENTANDO);
    timer_next = '0;
    pulso_next = 1'b0;
    rep_next   = 1'b0;
    if (ativo_next) begin
      if (state_next != state) begin
        timer_next = CARGA_ATRASO;
        pulso_next = 1'b1;
      end else if (timer == '0) begin
        timer_next = CARGA_PER;
        pulso_next = 1'b1;
        rep_next   = 1'b1;
      end else begin
        timer_next = timer - TW'(1);
        rep_next   = em_repeticao;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ESPERANDO;
      timer              <= '0;
      habilitar_contagem <= 1'b0;
      modo_contagem      <= 1'b0;
      em_repeticao       <= 1'b0;
    end else begin
      state              <= state_next;
      timer              <= timer_next;
      habilitar_contagem <= pulso_next;
      modo_contagem      <= (state_next == DECREMENTANDO);
      em_repeticao       <= rep_next;
    end
  end

endmodule

// File: tb/tb_interface_de_entrada_autorep.sv
// Bench for interface_de_entrada_autorep: vector table, directed bounce/reset
// sequences and random holds, all checked against a cycle-level step model.
module tb_interface_de_entrada_autorep;

  localparam int DEB = 4;
  localparam int ATR = 16;
  localparam int PER = 4;

  logic clock;
  logic reset;
  logic btn_mais;
  logic btn_menos;
  logic habilitar_contagem;
  logic modo_contagem;
  logic em_repeticao;

  interface_de_entrada_autorep #(
    .DEB_CICLOS (DEB),
    .ATRASO_REP (ATR),
    .PERIODO_REP(PER)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .btn_mais          (btn_mais),
    .btn_menos         (btn_menos),
    .habilitar_contagem(habilitar_contagem),
    .modo_contagem     (modo_contagem),
    .em_repeticao      (em_repeticao)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: steps follow from how long the current press has lasted.
  typedef enum int {M_ESP, M_INC, M_DEC, M_BLQ} mstate_t;
  mstate_t    m_state = M_ESP;
  int         m_age   = 0;
  bit [1:0]   m_s1    = '0;
  bit [1:0]   m_s2    = '0;
  bit [1:0]   m_filt  = '0;
  bit [31:0]  m_hist [2];
  int         m_hlen [2];
  bit         exp_pulse = 1'b0;
  bit         exp_modo  = 1'b0;
  bit         exp_em    = 1'b0;

  task automatic model_edge(input bit r, input bit m, input bit n);
    mstate_t ns;
    bool_loop: begin end
    if (r) begin
      m_state = M_ESP; m_age = 0; m_s1 = '0; m_s2 = '0; m_filt = '0;
      m_hist[0] = '0; m_hist[1] = '0; m_hlen[0] = 0; m_hlen[1] = 0;
      exp_pulse = 0; exp_modo = 0; exp_em = 0;
    end else begin
      ns = m_state;
      case (m_state)
        M_ESP: ns = (m_filt == 2'b11) ? M_BLQ : (m_filt == 2'b01) ? M_INC :
                    (m_filt == 2'b10) ? M_DEC : M_ESP;
        M_INC: ns = m_filt[1] ? M_BLQ : (!m_filt[0] ? M_ESP : M_INC);
        M_DEC: ns = m_filt[0] ? M_BLQ : (!m_filt[1] ? M_ESP : M_DEC);
        default: ns = (m_filt == 2'b00) ? M_ESP : M_BLQ;
      endcase
      if (ns == M_INC || ns == M_DEC) begin
        m_age     = (ns == m_state) ? m_age + 1 : 0;
        exp_pulse = (m_age == 0) || (m_age >= ATR && ((m_age - ATR) % PER) == 0);
        exp_em    = (m_age >= ATR);
      end else begin
        m_age = 0; exp_pulse = 0; exp_em = 0;
      end
      exp_modo = (ns == M_DEC);
      m_state  = ns;
      for (int i = 0; i < 2; i++) begin
        bit all_diff;
        m_hist[i] = {m_hist[i][30:0], m_s2[i]};
        if (m_hlen[i] < 32) m_hlen[i]++;
        all_diff = (m_hlen[i] >= DEB);
        for (int k = 0; k < DEB; k++)
          if (m_hist[i][k] == m_filt[i]) all_diff = 0;
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
      m_s2 = m_s1;
      m_s1 = {n, m};
    end
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  // Drive inputs for one cycle, advance the model on the same edge, compare after it.
  task automatic apply_stimulus(input bit r, input bit m, input bit n);
    reset = r; btn_mais = m; btn_menos = n;
    @(posedge clock);
    model_edge(r, m, n);
    #1;
    check_output("model habilitar_contagem", int'(habilitar_contagem), int'(exp_pulse));
    check_output("model modo_contagem",      int'(modo_contagem),      int'(exp_modo));
    check_output("model em_repeticao",       int'(em_repeticao),       int'(exp_em));
  endtask

  typedef struct {
    string name;
    bit    rst;
    bit    mais;
    bit    menos;
    int    cycles;
    int    pulses;
    bit    last_pulse;
    bit    modo;
    bit    em;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int pulses;
    int first_edge;

    reset = 1'b1; btn_mais = 1'b0; btn_menos = 1'b0;

    vecs[0]  = '{"reset",           1, 0, 0,  2, 0, 0, 0, 0};
    vecs[1]  = '{"mais first step", 0, 1, 0,  7, 1, 1, 0, 0};
    vecs[2]  = '{"mais delay",      0, 1, 0, 16, 1, 1, 0, 1};
    vecs[3]  = '{"mais repeat",     0, 1, 0,  8, 2, 1, 0, 1};
    vecs[4]  = '{"mais release",    0, 0, 0, 10, 1, 0, 0, 0};
    vecs[5]  = '{"menos first",     0, 0, 1,  7, 1, 1, 1, 0};
    vecs[6]  = '{"both block",      0, 1, 1, 10, 0, 0, 0, 0};
    vecs[7]  = '{"menos held blk",  0, 0, 1, 12, 0, 0, 0, 0};
    vecs[8]  = '{"both released",   0, 0, 0, 10, 0, 0, 0, 0};
    vecs[9]  = '{"menos glitch",    0, 0, 1,  3, 0, 0, 0, 0};
    vecs[10] = '{"after glitch",    0, 0, 0,  6, 0, 0, 0, 0};

    foreach (vecs[v]) begin
      pulses = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        apply_stimulus(vecs[v].rst, vecs[v].mais, vecs[v].menos);
        if (habilitar_contagem === 1'b1) pulses++;
      end
      check_output({vecs[v].name, " pulses"},     pulses, vecs[v].pulses);
      check_output({vecs[v].name, " last pulse"}, int'(habilitar_contagem), int'(vecs[v].last_pulse));
      check_output({vecs[v].name, " modo"},       int'(modo_contagem), int'(vecs[v].modo));
      check_output({vecs[v].name, " em"},         int'(em_repeticao), int'(vecs[v].em));
    end

    // Bouncing press: two-cycle toggles, then stable from edge 9.
    for (int c = 0; c < 12; c++) apply_stimulus(0, 0, 0);
    pulses = 0; first_edge = -1;
    for (int e = 1; e <= 30; e++) begin
      apply_stimulus(0, (e > 10) || (((e - 1) / 2) % 2 == 0), 0);
      if (habilitar_contagem === 1'b1) begin
        pulses++;
        if (first_edge < 0) first_edge = e;
      end
    end
    check_output("bounce pulse count", pulses, 1);
    check_output("bounce first edge",  first_edge, 15);
    for (int c = 0; c < 12; c++) apply_stimulus(0, 0, 0);

    // Reset in the middle of a repeating hold.
    for (int e = 1; e <= 30; e++) apply_stimulus(0, 1, 0);
    check_output("hold em before reset", int'(em_repeticao), 1);
    apply_stimulus(1, 1, 0);
    check_output("reset habilitar", int'(habilitar_contagem), 0);
    check_output("reset modo",      int'(modo_contagem), 0);
    check_output("reset em",        int'(em_repeticao), 0);
    pulses = 0; first_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(0, 1, 0);
      if (habilitar_contagem === 1'b1) begin
        pulses++;
        if (first_edge < 0) first_edge = e;
      end
    end
    check_output("post reset pulses",     pulses, 1);
    check_output("post reset first edge", first_edge, 7);
    for (int c = 0; c < 12; c++) apply_stimulus(0, 0, 0);

    // Random held levels with occasional resets.
    for (int s = 0; s < 80; s++) begin
      bit r;
      bit m;
      bit n;
      int len;
      r   = ($urandom_range(0, 19) == 0);
      m   = 1'($urandom_range(0, 1));
      n   = 1'($urandom_range(0, 1));
      len = r ? 1 : int'($urandom_range(1, 40));
      for (int c = 0; c < len; c++) apply_stimulus(r, m, n);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/interface_de_entrada_autorep.md
INTERFACE_DE_ENTRADA_AUTOREP -- requirements
Module: interface_de_entrada_autorep

Interface
REQ-001 Parameter DEB_CICLOS, default 4, SHALL set the button debounce stability window in clock cycles (legal range >=1).
REQ-002 Parameter ATRASO_REP, default 16, SHALL set the cycles from first step to first auto-repeat step (legal range >=1).
REQ-003 Parameter PERIODO_REP, default 4, SHALL set the cycles between consecutive auto-repeat steps (legal range >=1).
REQ-004 Port clock, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port btn_mais, input, 1 bit: raw asynchronous increment button, 1 = pressed.
REQ-007 Port btn_menos, input, 1 bit: raw asynchronous decrement button, 1 = pressed.
REQ-008 Port habilitar_contagem, output, 1 bit: registered one-cycle step pulse.
REQ-009 Port modo_contagem, output, 1 bit: registered direction, 0 = increment, 1 = decrement; valid whenever habilitar_contagem=1.
REQ-010 Port em_repeticao, output, 1 bit: registered flag, 1 while auto-repeat is active.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL feed a debouncer; its filtered level SHALL change only after the synchronized value differs from the filtered level for DEB_CICLOS consecutive cycles, with the stability count restarting on any reversion.
REQ-013 The FSM SHALL have states ESPERANDO, INCREMENTANDO, DECREMENTANDO, BLOQUEADO, driven only by the filtered levels fm (mais) and fn (menos).
REQ-014 ESPERANDO: fm=1,fn=0 -> INCREMENTANDO; fm=0,fn=1 -> DECREMENTANDO; fm=1,fn=1 -> BLOQUEADO; otherwise remain.
REQ-015 INCREMENTANDO: fn=1 -> BLOQUEADO; else fm=0 -> ESPERANDO; else remain. DECREMENTANDO symmetric with fm/fn swapped.
REQ-016 BLOQUEADO: fm=0 and fn=0 -> ESPERANDO; otherwise remain; no steps are generated in BLOQUEADO.
REQ-017 On the edge entering INCREMENTANDO or DECREMENTANDO, habilitar_contagem SHALL be 1 for exactly that next cycle, and the repeat timer SHALL load ATRASO_REP-1.
REQ-018 While remaining in INCREMENTANDO/DECREMENTANDO, the timer SHALL decrement each cycle; when it reaches 0, a one-cycle step pulse SHALL be issued, the timer reloaded with PERIODO_REP-1, and em_repeticao set to 1.
REQ-019 Step spacing SHALL be: first step at entry, second ATRASO_REP cycles later, then every PERIODO_REP cycles while held.
REQ-020 modo_contagem SHALL be 0 in ESPERANDO, INCREMENTANDO and BLOQUEADO, and 1 in DECREMENTANDO.
REQ-021 em_repeticao and the timer SHALL clear on any transition out of INCREMENTANDO/DECREMENTANDO.
REQ-022 Latency from a clean raw press to the first habilitar_contagem pulse SHALL be 2+DEB_CICLOS+1 cycles.
REQ-023 Direct INCREMENTANDO<->DECREMENTANDO transitions SHALL NOT exist; a direction change SHALL pass through ESPERANDO or BLOQUEADO.

Reset
REQ-024 With reset=1 at a rising edge: synchronizers, filtered levels, debounce counters and timer -> 0; state -> ESPERANDO; habilitar_contagem=0, modo_contagem=0, em_repeticao=0.
REQ-025 Reset asserted mid-hold SHALL abort repetition immediately; after release, a still-held button SHALL be re-debounced and produce a fresh first step per REQ-022.

Verification (defaults DEB=4, ATRASO=16, PERIODO=4)
REQ-026 Press btn_mais, hold 60 cycles -> first pulse 7 cycles after press, then pulses at +16, +20, +24 ...; modo_contagem=0; em_repeticao=1 from the second pulse.
REQ-027 btn_menos glitch high for 3 cycles -> no pulse, state stays ESPERANDO.
REQ-028 Hold btn_menos, press btn_mais during repetition -> BLOQUEADO, pulses stop, modo_contagem=0; release btn_mais only -> no further pulses until both are released and btn_menos is pressed again.
REQ-029 Bouncing press (toggle every 2 cycles for 10 cycles, then stable 1) -> exactly one first pulse, issued 2+4+1 cycles after becoming stable.
REQ-030 Assert reset for 1 cycle at hold cycle 30 -> all outputs 0 the next cycle; with the button still held, first pulse 7 cycles after reset release.
